// File: rtl/if_buffer_writer.sv
// Producer side of the IF input buffer: walks a num_rows x row_len SRAM window and
// pushes each word into the IF FIFO tagged with first/last-of-row flags.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing SRAM reads for the window
// DRAIN | all reads issued, flushing in-flight read and skid buffer
// DONE  | one-cycle completion pulse
module if_buffer_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_LEN   = 10,
  parameter int LEN_W      = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_LEN-1:0]   base_addr,
  input  logic [ADDR_LEN-1:0]   row_pitch,
  input  logic [LEN_W-1:0]      row_len,
  input  logic [LEN_W-1:0]      num_rows,
  output logic                  mem_ren,
  output logic [ADDR_LEN-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  if_buf_full,
  output logic                  if_buf_write,
  output logic [DATA_WIDTH+1:0] if_buf_dout,
  output logic                  busy,
  output logic                  done
);

  localparam int EW = DATA_WIDTH + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [LEN_W-1:0]    row_len_q, row_len_d;
  logic [LEN_W-1:0]    num_rows_q, num_rows_d;
  logic [LEN_W-1:0]    col_q, col_d;
  logic [LEN_W-1:0]    row_q, row_d;
  logic [ADDR_LEN-1:0] row_pitch_q, row_pitch_d;
  logic [ADDR_LEN-1:0] row_base_q, row_base_d;
  logic                inflight_q, inflight_d;
  logic                pipe_sof_q, pipe_sof_d;
  logic                pipe_eof_q, pipe_eof_d;
  logic [1:0][EW-1:0]  ent_q, ent_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          cnt_q, cnt_d;

  logic                push;
  logic                issue;
  logic                col_last;
  logic                row_last;
  logic [2:0]          occ_after;

  always_comb begin
    push      = (cnt_q != 2'd0) && !if_buf_full;
    col_last  = (col_q == row_len_q - LEN_W'(1));
    row_last  = (row_q == num_rows_q - LEN_W'(1));
    // Occupancy after this cycle's push and landing read, so a word leaving
    // the skid frees a slot in the same cycle and 1 word/cycle is sustained.
    occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, push};
    issue     = (state_q == S_FETCH) && (occ_after < 3'd2);
    cnt_d     = cnt_q + {1'b0, inflight_q} - {1'b0, push};

    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    row_pitch_d = row_pitch_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    ent_d       = ent_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    inflight_d  = issue;
    pipe_sof_d  = (col_q == '0);
    pipe_eof_d  = col_last;

    if (inflight_q) begin
      ent_d[wr_ptr_q] = {pipe_sof_q, pipe_eof_q, mem_rdata};
      wr_ptr_d        = !wr_ptr_q;
    end
    if (push) begin
      rd_ptr_d = !rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_len == '0 || num_rows == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FETCH;
            row_len_d   = row_len;
            num_rows_d  = num_rows;
            row_pitch_d = row_pitch;
            col_d       = '0;
            row_d       = '0;
            row_base_d  = base_addr;
          end
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (col_last) begin
            col_d      = '0;
            row_d      = row_q + LEN_W'(1);
            row_base_d = row_base_q + row_pitch_q;
            if (row_last) begin
              state_d = S_DRAIN;
            end
          end else begin
            col_d = col_q + LEN_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_d == 2'd0 && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      row_pitch_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      inflight_q  <= 1'b0;
      pipe_sof_q  <= 1'b0;
      pipe_eof_q  <= 1'b0;
      ent_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      row_pitch_q <= row_pitch_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      inflight_q  <= inflight_d;
      pipe_sof_q  <= pipe_sof_d;
      pipe_eof_q  <= pipe_eof_d;
      ent_q       <= ent_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_ren      = issue;
  assign mem_raddr    = row_base_q + ADDR_LEN'(col_q);
  assign if_buf_write = push;
  assign if_buf_dout  = ent_q[rd_ptr_q];
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_if_buffer_writer.sv
// Directed bench for if_buffer_writer: SRAM responder, push/read monitor and
// one task per scenario with hand-derived expected streams.
module tb_if_buffer_writer;
  localparam int DW = 8;
  localparam int AL = 10;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AL-1:0] base_addr;
  logic [AL-1:0] row_pitch;
  logic [LW-1:0] row_len;
  logic [LW-1:0] num_rows;
  logic          mem_ren;
  logic [AL-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_buf_full;
  logic          if_buf_write;
  logic [DW+1:0] if_buf_dout;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  if_buffer_writer #(.DATA_WIDTH(DW), .ADDR_LEN(AL), .LEN_W(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .row_pitch(row_pitch), .row_len(row_len), .num_rows(num_rows),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .if_buf_full(if_buf_full), .if_buf_write(if_buf_write),
    .if_buf_dout(if_buf_dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AL-1:0] a);
    return a[7:0] ^ {a[9:8], 6'b101101};
  endfunction

  always @(posedge clk) if (mem_ren) mem_rdata <= mem_f(mem_raddr);

  logic [DW+1:0] push_q[$];
  int            push_cyc[$];
  logic [AL-1:0] addr_q[$];
  int done_cnt, done_cyc, ren_total, push_total, max_out, wr_full_cnt;

  always @(negedge clk) begin
    if (mem_ren) begin
      addr_q.push_back(mem_raddr);
      ren_total++;
    end
    if (if_buf_write) begin
      push_q.push_back(if_buf_dout);
      push_cyc.push_back(cyc);
      push_total++;
      if (if_buf_full) wr_full_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ren_total - push_total > max_out) max_out = ren_total - push_total;
  end

  task automatic clear_mon();
    push_q.delete(); push_cyc.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; ren_total = 0; push_total = 0;
    max_out = 0; wr_full_cnt = 0;
  endtask

  // st_cyc is the cyc value in the first cycle after the edge that accepts start.
  task automatic run_job(input logic [AL-1:0] b, input logic [AL-1:0] p,
                         input logic [LW-1:0] rl, input logic [LW-1:0] nr,
                         input int f_lo, input int f_hi,
                         output int st_cyc, output bit ok);
    @(posedge clk); #1;
    clear_mon();
    base_addr = b; row_pitch = p; row_len = rl; num_rows = nr; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    st_cyc = cyc;
    ok     = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if_buf_full = (cyc - st_cyc >= f_lo) && (cyc - st_cyc <= f_hi);
      @(posedge clk); #1;
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if_buf_full = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [AL-1:0] exp_addr(input logic [AL-1:0] b, input logic [AL-1:0] p,
                                             input int r, input int c);
    return b + AL'(r) * p + AL'(c);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; if_buf_full = 1'b0;
    base_addr = '0; row_pitch = '0; row_len = '0; num_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ren: got %b expected 0", mem_ren); end
    n_checks++; if (mem_raddr !== '0) begin n_fail++; $display("FAIL reset_mem_raddr: got %h expected 0", mem_raddr); end
    n_checks++; if (if_buf_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", if_buf_write); end
    n_checks++; if (if_buf_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", if_buf_dout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk); rstn = 1'b1;
  endtask

  // T1/T2 window: base 0x010, pitch 0x020, 4 words x 3 rows.
  task automatic test_basic(input int f_lo, input int f_hi, input string nm);
    int st; bit ok; int k; logic [AL-1:0] a; logic [DW+1:0] w;
    run_job(10'h010, 10'h020, 6'd4, 6'd3, f_lo, f_hi, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: done not seen within bound", nm); end
    n_checks++; if (push_q.size() != 12) begin n_fail++; $display("FAIL %s_push_count: got %0d expected 12", nm, push_q.size()); end
    n_checks++; if (addr_q.size() != 12) begin n_fail++; $display("FAIL %s_read_count: got %0d expected 12", nm, addr_q.size()); end
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        a = exp_addr(10'h010, 10'h020, r, c);
        w = {c == 0, c == 3, mem_f(a)};
        if (k < addr_q.size()) begin
          n_checks++;
          if (addr_q[k] !== a) begin n_fail++; $display("FAIL %s_addr[%0d]: got %h expected %h", nm, k, addr_q[k], a); end
        end
        if (k < push_q.size()) begin
          n_checks++;
          if (push_q[k] !== w) begin n_fail++; $display("FAIL %s_word[%0d]: got %h expected %h", nm, k, push_q[k], w); end
        end
        k++;
      end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", nm, done_cnt); end
    if (push_cyc.size() == 12) begin
      n_checks++;
      if (done_cyc != push_cyc[11] + 1) begin n_fail++; $display("FAIL %s_done_latency: got %0d expected %0d", nm, done_cyc, push_cyc[11] + 1); end
      n_checks++;
      if (push_cyc[0] != st + 2) begin n_fail++; $display("FAIL %s_first_push: got %0d expected %0d", nm, push_cyc[0], st + 2); end
      if (f_lo > f_hi) begin
        n_checks++;
        if (push_cyc[11] - push_cyc[0] != 11) begin n_fail++; $display("FAIL %s_throughput: got span %0d expected 11", nm, push_cyc[11] - push_cyc[0]); end
      end
    end
    n_checks++; if (wr_full_cnt != 0) begin n_fail++; $display("FAIL %s_push_while_full: got %0d expected 0", nm, wr_full_cnt); end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL %s_outstanding: got %0d expected <=2", nm, max_out); end
  endtask

  task automatic test_row_len_one();
    int st; bit ok; logic [AL-1:0] a;
    run_job(10'h100, 10'h003, 6'd1, 6'd5, 1, 0, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_timeout: done not seen within bound"); end
    n_checks++; if (push_q.size() != 5) begin n_fail++; $display("FAIL t3_push_count: got %0d expected 5", push_q.size()); end
    for (int r = 0; r < 5 && r < push_q.size(); r++) begin
      a = 10'h100 + AL'(3 * r);
      n_checks++;
      if (push_q[r] !== {2'b11, mem_f(a)}) begin n_fail++; $display("FAIL t3_word[%0d]: got %h expected %h", r, push_q[r], {2'b11, mem_f(a)}); end
    end
  endtask

  task automatic test_empty_job(input logic [LW-1:0] rl, input logic [LW-1:0] nr);
    int st; bit ok;
    run_job(10'h055, 10'h010, rl, nr, 1, 0, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_timeout rl=%0d nr=%0d: done not seen", rl, nr); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t4_done_pulses: got %0d expected 1", done_cnt); end
    // IDLE->DONE on the accepting edge: done is high in the very next cycle.
    n_checks++; if (done_cyc != st) begin n_fail++; $display("FAIL t4_done_cycle: got %0d expected %0d", done_cyc, st); end
    n_checks++; if (ren_total != 0) begin n_fail++; $display("FAIL t4_reads: got %0d expected 0", ren_total); end
    n_checks++; if (push_total != 0) begin n_fail++; $display("FAIL t4_pushes: got %0d expected 0", push_total); end
  endtask

  task automatic test_wrap();
    int st; bit ok; logic [AL-1:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    run_job(10'h3FE, 10'h001, 6'd4, 6'd1, 1, 0, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_timeout: done not seen within bound"); end
    n_checks++; if (addr_q.size() != 4) begin n_fail++; $display("FAIL t5_read_count: got %0d expected 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_checks++;
      if (addr_q[i] !== exp_a[i]) begin n_fail++; $display("FAIL t5_addr[%0d]: got %h expected %h", i, addr_q[i], exp_a[i]); end
    end
    for (int i = 0; i < 4 && i < push_q.size(); i++) begin
      n_checks++;
      if (push_q[i] !== {i == 0, i == 3, mem_f(exp_a[i])}) begin n_fail++; $display("FAIL t5_word[%0d]: got %h expected %h", i, push_q[i], {i == 0, i == 3, mem_f(exp_a[i])}); end
    end
  endtask

  task automatic test_reset_mid_job();
    int st; bit ok; logic [DW+1:0] w; logic [AL-1:0] a; logic [DW+AL+5:0] outs;
    @(posedge clk); #1;
    clear_mon();
    base_addr = 10'h010; row_pitch = 10'h020; row_len = 6'd4; num_rows = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (push_total >= 5) break;
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    outs = {mem_ren, mem_raddr, if_buf_write, if_buf_dout, busy, done};
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL t6_outputs_in_reset: got %h expected 0", outs); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (push_total != 5) begin n_fail++; $display("FAIL t6_pushes_before_reset: got %0d expected 5", push_total); end
    rstn = 1'b1;
    run_job(10'h020, 10'h010, 6'd2, 6'd2, 1, 0, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_timeout: done not seen within bound"); end
    n_checks++; if (push_q.size() != 4) begin n_fail++; $display("FAIL t6_push_count: got %0d expected 4", push_q.size()); end
    for (int i = 0; i < 4 && i < push_q.size(); i++) begin
      a = 10'h020 + AL'((i / 2) * 16 + (i % 2));
      w = {i % 2 == 0, i % 2 == 1, mem_f(a)};
      n_checks++;
      if (push_q[i] !== w) begin n_fail++; $display("FAIL t6_word[%0d]: got %h expected %h", i, push_q[i], w); end
    end
  endtask

  task automatic test_start_while_busy();
    int st; bit ok;
    // A second start pulse mid-job must not restart or disturb the walk.
    fork
      begin
        repeat (4) @(posedge clk);
        #2;
        base_addr = 10'h200; row_len = 6'd1; num_rows = 6'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    join_none
    run_job(10'h010, 10'h020, 6'd4, 6'd3, 1, 0, st, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout: done not seen within bound"); end
    n_checks++; if (push_q.size() != 12) begin n_fail++; $display("FAIL busy_start_push_count: got %0d expected 12", push_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic(1, 0, "t1");
    test_basic(3, 9, "t2");
    test_row_len_one();
    test_empty_job(6'd0, 6'd3);
    test_empty_job(6'd4, 6'd0);
    test_wrap();
    test_reset_mid_job();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
